tlul_host_arb: RTL

Two-host TL-UL arbiter that shares the single device-side port of `access_control_wrapper`'s PMP host interface (`tl_h2pmp`/`tl_pmp2h`) between two requesters, e.g. the CPU data port and a DMA engine. Round-robin arbitration runs on the A channel. An in-order tracking FIFO routes every D-channel response back to the host that issued the request. The block sits directly upstream of the wrapper, and one instance per wrapper copy is used in the equivalence miter.

---
 rtl/tlul_pkg.sv | 28 ++
 rtl/tlul_host_arb.sv | 116 +++++++++++
 2 files changed

// File: rtl/tlul_pkg.sv
// Minimal TL-UL channel structs shared by the host arbiter and its bench.
package tlul_pkg;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_host_arb.sv
// Two-host TL-UL arbiter: round-robin on A, in-order id FIFO steering D
// responses back to the issuing host.
module tlul_host_arb #(
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  tlul_pkg::tl_h2d_t                     tl_h0_i,
  output tlul_pkg::tl_d2h_t                     tl_h0_o,
  input  tlul_pkg::tl_h2d_t                     tl_h1_i,
  output tlul_pkg::tl_d2h_t                     tl_h1_o,
  output tlul_pkg::tl_h2d_t                     tl_dev_o,
  input  tlul_pkg::tl_d2h_t                     tl_dev_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
  output logic                                  err_unexpected_o
);

  localparam int unsigned PW = $clog2(MaxOutstanding);
  localparam int unsigned CW = $clog2(MaxOutstanding + 1);

  logic                      rr_last_q;
  logic                      lock_q;
  logic                      lock_id_q;
  logic                      err_q;
  logic [MaxOutstanding-1:0] fifo_q;
  logic [PW-1:0]             wptr_q;
  logic [PW-1:0]             rptr_q;
  logic [CW-1:0]             count_q;

  logic              grant;
  logic              full;
  logic              empty;
  logic              head;
  logic              dev_a_valid;
  logic              dev_d_ready;
  logic              a_hs;
  logic              d_hs;
  logic              unexpected_d;
  tlul_pkg::tl_h2d_t granted_req;

  // A held lock pins the grant so a stalled request never changes source.
  always_comb begin
    grant = ~rr_last_q;
    if (lock_q) begin
      grant = lock_id_q;
    end else if (tl_h0_i.a_valid && !tl_h1_i.a_valid) begin
      grant = 1'b0;
    end else if (!tl_h0_i.a_valid && tl_h1_i.a_valid) begin
      grant = 1'b1;
    end
  end

  assign full         = (count_q == CW'(MaxOutstanding));
  assign empty        = (count_q == '0);
  assign head         = fifo_q[rptr_q];
  assign granted_req  = grant ? tl_h1_i : tl_h0_i;

  assign dev_a_valid  = rst && granted_req.a_valid && !full;
  assign dev_d_ready  = rst && (empty ? 1'b1 : (head ? tl_h1_i.d_ready : tl_h0_i.d_ready));
  assign a_hs         = dev_a_valid && tl_dev_i.a_ready;
  assign d_hs         = !empty && tl_dev_i.d_valid && dev_d_ready;
  assign unexpected_d = empty && tl_dev_i.d_valid;

  // Handshake qualifiers are gated by rst so reset silences the bus at once.
  always_comb begin
    tl_dev_o         = granted_req;
    tl_dev_o.a_valid = dev_a_valid;
    tl_dev_o.d_ready = dev_d_ready;

    tl_h0_o          = tl_dev_i;
    tl_h0_o.a_ready  = rst && !grant && tl_dev_i.a_ready && !full;
    tl_h0_o.d_valid  = rst && !empty && !head && tl_dev_i.d_valid;

    tl_h1_o          = tl_dev_i;
    tl_h1_o.a_ready  = rst && grant && tl_dev_i.a_ready && !full;
    tl_h1_o.d_valid  = rst && !empty && head && tl_dev_i.d_valid;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_last_q <= 1'b1;
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      err_q     <= 1'b0;
      fifo_q    <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
    end else begin
      lock_q <= dev_a_valid && !tl_dev_i.a_ready;
      if (dev_a_valid && !tl_dev_i.a_ready) begin
        lock_id_q <= grant;
      end
      if (a_hs) begin
        fifo_q[wptr_q] <= grant;
        wptr_q         <= wptr_q + PW'(1);
        rr_last_q      <= grant;
      end
      if (d_hs) begin
        rptr_q <= rptr_q + PW'(1);
      end
      if (a_hs && !d_hs) begin
        count_q <= count_q + CW'(1);
      end else if (!a_hs && d_hs) begin
        count_q <= count_q - CW'(1);
      end
      if (unexpected_d) begin
        err_q <= 1'b1;
      end
    end
  end

  assign outstanding_o    = count_q;
  assign err_unexpected_o = err_q;

endmodule
